// File: rtl/wb_arbiter_rr2.sv
// Two-master round-robin Wishbone classic arbiter for the USB register bus,
// with a per-grant bus-hang watchdog and saturating timeout counter.
module wb_arbiter_rr2 #(
  parameter int ADR_W      = 14,
  parameter int DAT_W      = 32,
  parameter int TMO_CYCLES = 255,
  parameter int TMO_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_cyc,
  input  logic               m0_stb,
  input  logic               m0_we,
  input  logic [ADR_W-1:0]   m0_adr,
  input  logic [DAT_W/8-1:0] m0_sel,
  input  logic [DAT_W-1:0]   m0_dat_mosi,
  output logic               m0_ack,
  output logic               m0_err,
  output logic [DAT_W-1:0]   m0_dat_miso,
  input  logic               m1_cyc,
  input  logic               m1_stb,
  input  logic               m1_we,
  input  logic [ADR_W-1:0]   m1_adr,
  input  logic [DAT_W/8-1:0] m1_sel,
  input  logic [DAT_W-1:0]   m1_dat_mosi,
  output logic               m1_ack,
  output logic               m1_err,
  output logic [DAT_W-1:0]   m1_dat_miso,
  output logic               s_cyc,
  output logic               s_stb,
  output logic               s_we,
  output logic [ADR_W-1:0]   s_adr,
  output logic [DAT_W/8-1:0] s_sel,
  output logic [DAT_W-1:0]   s_dat_mosi,
  input  logic               s_ack,
  input  logic [DAT_W-1:0]   s_dat_miso,
  output logic [1:0]         grant,
  output logic [7:0]         tmo_count
);

  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(TMO_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    G0,
    G1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last;
  logic             last_nxt;
  logic [TMO_W-1:0] wdog;
  logic [TMO_W-1:0] wdog_nxt;
  logic             g0;
  logic             g1;
  logic             sel_cyc;
  logic             sel_stb;
  logic             tmo_hit;
  logic             ack_fwd;

  assign g0 = (state == G0);
  assign g1 = (state == G1);

  always_comb begin
    sel_cyc    = 1'b0;
    sel_stb    = 1'b0;
    s_we       = 1'b0;
    s_adr      = '0;
    s_sel      = '0;
    s_dat_mosi = '0;
    unique case (1'b1)
      g0: begin
        sel_cyc    = m0_cyc;
        sel_stb    = m0_cyc & m0_stb;
        s_we       = m0_we;
        s_adr      = m0_adr;
        s_sel      = m0_sel;
        s_dat_mosi = m0_dat_mosi;
      end
      g1: begin
        sel_cyc    = m1_cyc;
        sel_stb    = m1_cyc & m1_stb;
        s_we       = m1_we;
        s_adr      = m1_adr;
        s_sel      = m1_sel;
        s_dat_mosi = m1_dat_mosi;
      end
      default: ;
    endcase
  end

  // an ack arriving in the last watchdog cycle beats the timeout
  assign tmo_hit = sel_stb & ~s_ack & (wdog == TMO_LAST);
  assign ack_fwd = sel_stb & s_ack;

  assign s_cyc = sel_cyc & ~tmo_hit;
  assign s_stb = sel_stb & ~tmo_hit;

  assign grant       = {g1, g0};
  assign m0_ack      = g0 & ack_fwd;
  assign m1_ack      = g1 & ack_fwd;
  assign m0_err      = g0 & tmo_hit;
  assign m1_err      = g1 & tmo_hit;
  assign m0_dat_miso = g0 ? s_dat_miso : '0;
  assign m1_dat_miso = g1 ? s_dat_miso : '0;

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    wdog_nxt  = '0;
    unique case (state)
      IDLE: begin
        if (m0_cyc && (!m1_cyc || last)) begin
          state_nxt = G0;
          last_nxt  = 1'b0;
        end else if (m1_cyc) begin
          state_nxt = G1;
          last_nxt  = 1'b1;
        end
      end
      G0, G1: begin
        if (tmo_hit || !sel_cyc) begin
          state_nxt = IDLE;
        end else if (sel_stb && !s_ack) begin
          wdog_nxt = wdog + TMO_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      wdog      <= '0;
      tmo_count <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      wdog  <= wdog_nxt;
      if (tmo_hit && tmo_count != 8'hFF) begin
        tmo_count <= tmo_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter_rr2.sv
// Bench for wb_arbiter_rr2: directed scenarios plus randomized arbitration
// rounds checked against a transaction-level round-robin model.
module tb_wb_arbiter_rr2;

  localparam int ADR_W = 14;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;
  localparam int TMO   = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             m0_cyc, m0_stb, m0_we;
  logic [ADR_W-1:0] m0_adr;
  logic [SEL_W-1:0] m0_sel;
  logic [DAT_W-1:0] m0_dat_mosi;
  logic             m0_ack, m0_err;
  logic [DAT_W-1:0] m0_dat_miso;
  logic             m1_cyc, m1_stb, m1_we;
  logic [ADR_W-1:0] m1_adr;
  logic [SEL_W-1:0] m1_sel;
  logic [DAT_W-1:0] m1_dat_mosi;
  logic             m1_ack, m1_err;
  logic [DAT_W-1:0] m1_dat_miso;
  logic             s_cyc, s_stb, s_we;
  logic [ADR_W-1:0] s_adr;
  logic [SEL_W-1:0] s_sel;
  logic [DAT_W-1:0] s_dat_mosi;
  logic             s_ack;
  logic [DAT_W-1:0] s_dat_miso;
  logic [1:0]       grant;
  logic [7:0]       tmo_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit last_owner;
  int exp_tmo;

  wb_arbiter_rr2 #(
    .ADR_W(ADR_W), .DAT_W(DAT_W),
    .TMO_CYCLES(TMO), .TMO_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we),
    .m0_adr(m0_adr), .m0_sel(m0_sel),
    .m0_dat_mosi(m0_dat_mosi), .m0_ack(m0_ack),
    .m0_err(m0_err), .m0_dat_miso(m0_dat_miso),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we),
    .m1_adr(m1_adr), .m1_sel(m1_sel),
    .m1_dat_mosi(m1_dat_mosi), .m1_ack(m1_ack),
    .m1_err(m1_err), .m1_dat_miso(m1_dat_miso),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_adr(s_adr), .s_sel(s_sel),
    .s_dat_mosi(s_dat_mosi), .s_ack(s_ack),
    .s_dat_miso(s_dat_miso),
    .grant(grant), .tmo_count(tmo_count)
  );

  always #5 clk = ~clk;

  // round-robin rule: a tie goes to whoever did not own the bus last
  function automatic bit pick(bit r0, bit r1, bit last);
    if (r0 && r1) return !last;
    return r0 ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [1:0] onehot(bit n);
    return n ? 2'b10 : 2'b01;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive_m(input bit n, input bit cyc, input bit stb);
    if (!n) begin
      m0_cyc = cyc; m0_stb = stb;
      m0_we = 1'($urandom_range(0, 1));
      m0_adr = ADR_W'($urandom);
      m0_sel = SEL_W'($urandom);
      m0_dat_mosi = $urandom;
    end else begin
      m1_cyc = cyc; m1_stb = stb;
      m1_we = 1'($urandom_range(0, 1));
      m1_adr = ADR_W'($urandom);
      m1_sel = SEL_W'($urandom);
      m1_dat_mosi = $urandom;
    end
  endtask

  task automatic idle_all();
    drive_m(1'b0, 1'b0, 1'b0);
    drive_m(1'b1, 1'b0, 1'b0);
    s_ack = 1'b0;
    s_dat_miso = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_all();
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    last_owner = 1'b1;
    exp_tmo = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    drive_m(1'b0, 1'b1, 1'b1);
    drive_m(1'b1, 1'b1, 1'b1);
    s_ack = 1'b1;
    s_dat_miso = $urandom;
    tick();
    tick();
    settle();
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++; $display("FAIL reset_grant got=%b exp=00", grant);
    end
    n_checks++;
    if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin
      n_fail++; $display("FAIL reset_s_cyc_stb got=%b%b exp=00", s_cyc, s_stb);
    end
    n_checks++;
    if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || m0_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_ack_err got=%b%b%b exp=000", m0_ack, m1_ack, m0_err);
    end
    n_checks++;
    if (tmo_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_tmo_count got=%0d exp=0", tmo_count);
    end
    n_checks++;
    if (m0_dat_miso !== '0) begin
      n_fail++; $display("FAIL reset_dat_miso got=%h exp=0", m0_dat_miso);
    end
    rst = 1'b0;
    idle_all();
    tick();
    last_owner = 1'b1;
    exp_tmo = 0;
  endtask

  task automatic test_single_read();
    logic [DAT_W-1:0] d;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0;
    m0_adr = 14'h0010; m0_sel = 4'hF;
    settle();
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++; $display("FAIL read_latency grant got=%b exp=00", grant);
    end
    tick();
    settle();
    n_checks++;
    if (grant !== 2'b01 || s_cyc !== 1'b1 || s_adr !== 14'h0010 || s_we !== 1'b0) begin
      n_fail++;
      $display("FAIL read_grant got grant=%b cyc=%b adr=%h we=%b exp 01 1 0010 0", grant, s_cyc, s_adr, s_we);
    end
    tick();
    d = $urandom;
    s_ack = 1'b1; s_dat_miso = d;
    settle();
    n_checks++;
    if (m0_ack !== 1'b1 || m0_dat_miso !== d) begin
      n_fail++; $display("FAIL read_ack got ack=%b dat=%h exp 1 %h", m0_ack, m0_dat_miso, d);
    end
    n_checks++;
    if (m1_ack !== 1'b0 || m1_dat_miso !== '0) begin
      n_fail++; $display("FAIL read_m1_quiet got ack=%b dat=%h exp 0 0", m1_ack, m1_dat_miso);
    end
    tick();
    drive_m(1'b0, 1'b0, 1'b0);
    s_ack = 1'b0;
    settle();
    n_checks++;
    if (grant !== 2'b01 || s_cyc !== 1'b0) begin
      n_fail++; $display("FAIL read_release got grant=%b cyc=%b exp 01 0", grant, s_cyc);
    end
    tick();
    settle();
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++; $display("FAIL read_idle got=%b exp=00", grant);
    end
    tick();
    last_owner = 1'b0;
  endtask

  task automatic test_tie();
    do_reset();
    drive_m(1'b0, 1'b1, 1'b1);
    drive_m(1'b1, 1'b1, 1'b1);
    tick();
    settle();
    n_checks++;
    if (grant !== 2'b01 || s_adr !== m0_adr) begin
      n_fail++; $display("FAIL tie_first got grant=%b adr=%h exp 01 %h", grant, s_adr, m0_adr);
    end
    tick();
    s_ack = 1'b1;
    settle();
    n_checks++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
      n_fail++; $display("FAIL tie_ack got m0=%b m1=%b exp 1 0", m0_ack, m1_ack);
    end
    tick();
    drive_m(1'b0, 1'b0, 1'b0);
    s_ack = 1'b0;
    tick();
    settle();
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++; $display("FAIL tie_gap got=%b exp=00", grant);
    end
    tick();
    settle();
    n_checks++;
    if (grant !== 2'b10 || s_adr !== m1_adr) begin
      n_fail++; $display("FAIL tie_second got grant=%b adr=%h exp 10 %h", grant, s_adr, m1_adr);
    end
    tick();
    s_ack = 1'b1;
    settle();
    n_checks++;
    if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
      n_fail++; $display("FAIL tie_ack2 got m1=%b m0=%b exp 1 0", m1_ack, m0_ack);
    end
    tick();
    drive_m(1'b1, 1'b0, 1'b0);
    s_ack = 1'b0;
    tick();
    last_owner = 1'b1;
  endtask

  task automatic test_rounds(input int n, input bit both);
    for (int k = 0; k < n; k++) begin
      bit r0, r1, own;
      int nb;
      r0 = both ? 1'b1 : 1'($urandom_range(0, 1));
      r1 = (both || !r0) ? 1'b1 : 1'($urandom_range(0, 1));
      own = pick(r0, r1, last_owner);
      drive_m(1'b0, r0, r0);
      drive_m(1'b1, r1, r1);
      s_ack = 1'($urandom_range(0, 1));
      s_dat_miso = $urandom;
      settle();
      n_checks++;
      if (grant !== 2'b00 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
        n_fail++; $display("FAIL round%0d_idle got grant=%b acks=%b%b exp 00 00", k, grant, m0_ack, m1_ack);
      end
      tick();
      s_ack = 1'b0;
      settle();
      n_checks++;
      if (grant !== onehot(own)) begin
        n_fail++; $display("FAIL round%0d_grant got=%b exp=%b", k, grant, onehot(own));
      end
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        int lat;
        logic [DAT_W-1:0] d;
        lat = $urandom_range(0, 3);
        repeat (lat) begin
          settle();
          n_checks++;
          if (s_adr !== (own ? m1_adr : m0_adr) || s_we !== (own ? m1_we : m0_we) ||
              s_sel !== (own ? m1_sel : m0_sel) || s_dat_mosi !== (own ? m1_dat_mosi : m0_dat_mosi) ||
              s_stb !== 1'b1 || (own ? m1_ack : m0_ack) !== 1'b0) begin
            n_fail++; $display("FAIL round%0d_mux got adr=%h stb=%b exp adr=%h stb=1", k, s_adr, s_stb, own ? m1_adr : m0_adr);
          end
          tick();
        end
        d = $urandom;
        s_ack = 1'b1; s_dat_miso = d;
        settle();
        n_checks++;
        if ((own ? m1_ack : m0_ack) !== 1'b1 || (own ? m1_dat_miso : m0_dat_miso) !== d ||
            (own ? m0_ack : m1_ack) !== 1'b0 || (own ? m0_dat_miso : m1_dat_miso) !== '0) begin
          n_fail++; $display("FAIL round%0d_beat%0d acks=%b%b dat0=%h dat1=%h exp owner=%0d dat=%h", k, b, m0_ack, m1_ack, m0_dat_miso, m1_dat_miso, own, d);
        end
        tick();
        s_ack = 1'b0;
        if (b < nb - 1) drive_m(own, 1'b1, 1'b1);
      end
      drive_m(own, 1'b0, 1'b0);
      settle();
      n_checks++;
      if (grant !== onehot(own) || s_cyc !== 1'b0) begin
        n_fail++; $display("FAIL round%0d_release got grant=%b cyc=%b exp %b 0", k, grant, s_cyc, onehot(own));
      end
      tick();
      last_owner = own;
    end
  endtask

  task automatic test_hold();
    drive_m(1'b0, 1'b0, 1'b0);
    drive_m(1'b1, 1'b1, 1'b1);
    tick();
    settle();
    n_checks++;
    if (grant !== 2'b10) begin
      n_fail++; $display("FAIL hold_grant got=%b exp=10", grant);
    end
    tick();
    drive_m(1'b0, 1'b1, 1'b1);
    for (int b = 0; b < 3; b++) begin
      s_ack = 1'b1;
      settle();
      n_checks++;
      if (grant !== 2'b10 || m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
        n_fail++; $display("FAIL hold_beat%0d got grant=%b m1=%b m0=%b exp 10 1 0", b, grant, m1_ack, m0_ack);
      end
      tick();
      m1_stb = 1'b0;
      settle();
      n_checks++;
      if (grant !== 2'b10 || m1_ack !== 1'b0 || s_stb !== 1'b0 || s_cyc !== 1'b1) begin
        n_fail++; $display("FAIL hold_nostb%0d got grant=%b ack=%b stb=%b cyc=%b exp 10 0 0 1", b, grant, m1_ack, s_stb, s_cyc);
      end
      tick();
      s_ack = 1'b0;
      drive_m(1'b1, 1'b1, 1'b1);
    end
    drive_m(1'b1, 1'b0, 1'b0);
    tick();
    settle();
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++; $display("FAIL hold_gap got=%b exp=00", grant);
    end
    tick();
    settle();
    n_checks++;
    if (grant !== 2'b01) begin
      n_fail++; $display("FAIL hold_next got=%b exp=01", grant);
    end
    tick();
    s_ack = 1'b1;
    tick();
    drive_m(1'b0, 1'b0, 1'b0);
    s_ack = 1'b0;
    tick();
    last_owner = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    drive_m(1'b0, 1'b1, 1'b1);
    tick();
    for (int c = 1; c < TMO; c++) begin
      settle();
      n_checks++;
      if (m0_err !== 1'b0 || s_cyc !== 1'b1) begin
        n_fail++; $display("FAIL tmo_early%0d got err=%b cyc=%b exp 0 1", c, m0_err, s_cyc);
      end
      tick();
    end
    settle();
    n_checks++;
    if (m0_err !== 1'b1 || s_cyc !== 1'b0 || s_stb !== 1'b0 || m1_err !== 1'b0) begin
      n_fail++; $display("FAIL tmo_hit got err=%b cyc=%b stb=%b exp 1 0 0", m0_err, s_cyc, s_stb);
    end
    tick();
    drive_m(1'b0, 1'b0, 1'b0);
    exp_tmo = 1;
    last_owner = 1'b0;
    settle();
    n_checks++;
    if (grant !== 2'b00 || tmo_count !== 8'(exp_tmo) || m0_err !== 1'b0) begin
      n_fail++; $display("FAIL tmo_after got grant=%b cnt=%0d err=%b exp 00 %0d 0", grant, tmo_count, m0_err, exp_tmo);
    end
    tick();
    drive_m(1'b0, 1'b1, 1'b1);
    drive_m(1'b1, 1'b1, 1'b1);
    tick();
    settle();
    n_checks++;
    if (grant !== onehot(pick(1'b1, 1'b1, last_owner))) begin
      n_fail++; $display("FAIL tmo_rr got=%b exp=10", grant);
    end
    tick();
    s_ack = 1'b1;
    tick();
    drive_m(1'b1, 1'b0, 1'b0);
    s_ack = 1'b0;
    tick();
    tick();
    for (int c = 1; c < TMO; c++) tick();
    s_ack = 1'b1;
    s_dat_miso = $urandom;
    settle();
    n_checks++;
    if (grant !== 2'b01 || m0_err !== 1'b0 || m0_ack !== 1'b1 || s_cyc !== 1'b1) begin
      n_fail++; $display("FAIL tmo_ackwins got grant=%b err=%b ack=%b cyc=%b exp 01 0 1 1", grant, m0_err, m0_ack, s_cyc);
    end
    tick();
    drive_m(1'b0, 1'b0, 1'b0);
    s_ack = 1'b0;
    settle();
    n_checks++;
    if (tmo_count !== 8'(exp_tmo)) begin
      n_fail++; $display("FAIL tmo_ackwins_cnt got=%0d exp=%0d", tmo_count, exp_tmo);
    end
    tick();
    last_owner = 1'b0;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      drive_m(1'b0, 1'b1, 1'b1);
      tick();
      repeat (TMO - 1) tick();
      settle();
      n_checks++;
      if (m0_err !== 1'b1) begin
        n_fail++; $display("FAIL sat%0d_err got=%b exp=1", i, m0_err);
      end
      tick();
      drive_m(1'b0, 1'b0, 1'b0);
      exp_tmo = (exp_tmo >= 255) ? 255 : exp_tmo + 1;
      settle();
      n_checks++;
      if (tmo_count !== 8'(exp_tmo)) begin
        n_fail++; $display("FAIL sat%0d_cnt got=%0d exp=%0d", i, tmo_count, exp_tmo);
      end
      tick();
    end
    last_owner = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive_m(1'b1, 1'b1, 1'b1);
    tick();
    settle();
    n_checks++;
    if (grant !== 2'b10) begin
      n_fail++; $display("FAIL rstmid_grant got=%b exp=10", grant);
    end
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (grant !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async got grant=%b cyc=%b stb=%b exp 00 0 0", grant, s_cyc, s_stb);
    end
    n_checks++;
    if (tmo_count !== 8'd0) begin
      n_fail++; $display("FAIL rstmid_cnt got=%0d exp=0", tmo_count);
    end
    @(negedge clk);
    rst = 1'b0;
    last_owner = 1'b1;
    drive_m(1'b0, 1'b1, 1'b1);
    drive_m(1'b1, 1'b1, 1'b1);
    tick();
    settle();
    n_checks++;
    if (grant !== onehot(pick(1'b1, 1'b1, last_owner))) begin
      n_fail++; $display("FAIL rstmid_tie got=%b exp=01", grant);
    end
    tick();
    idle_all();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_rounds(8, 1'b1);
    test_rounds(12, 1'b0);
    test_hold();
    test_timeout();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
